lsu_mem_ctrl: RTL and testbench

Data-memory controller between the execute-stage load/store unit and the external data bus. It takes one memory operation per request: a 4-bit memory opcode, an effective address and store data. It runs a single-beat request/acknowledge transaction with byte enables and lane steering, then returns load data right-aligned to bit 0. Sign/zero extension stays in the load/store unit. The controller also detects misaligned accesses and bus timeouts, and stalls the pipeline while a transaction is in flight.

---
 rtl/lsu_mem_ctrl_pkg.sv | 33 +++
 rtl/mem_lane_align.sv | 58 +++++
 rtl/lsu_mem_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_lsu_mem_ctrl.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_mem_ctrl_pkg.sv
// Shared definitions for the data-memory controller and the load/store unit.
// Holds the opcode field positions, the size codes and the controller FSM
// state encoding, plus a helper that classifies misaligned accesses.
package lsu_mem_ctrl_pkg;

    // Opcode field positions: bit 3 store, bit 2 unsigned load, [1:0] size.
    localparam int unsigned OpStoreBit    = 3;
    localparam int unsigned OpUnsignedBit = 2;
    localparam int unsigned OpSizeLsb     = 0;

    // Size codes; 2'b00 is also treated as a word access.
    localparam logic [1:0] SizeByte = 2'b01;
    localparam logic [1:0] SizeHalf = 2'b10;
    localparam logic [1:0] SizeWord = 2'b11;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StBus  = 2'b01,
        StDone = 2'b10
    } mem_state_e;

    // Halves need addr[0]=0, words need addr[1:0]=0, bytes are always aligned.
    function automatic logic is_misaligned(logic [1:0] size, logic [1:0] addr_lo);
        logic mis;
        case (size)
            SizeByte: mis = 1'b0;
            SizeHalf: mis = addr_lo[0];
            default:  mis = (addr_lo != 2'b00);
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering for the data-memory controller.
// Ports:
//   size_i     access size code (byte/half/word; 2'b00 treated as word)
//   addr_lo_i  low two bits of the effective address
//   wdata_i    store data, right-aligned
//   rdata_i    read word from the bus
//   be_o       byte enables for the access
//   wdata_o    store data replicated across all lanes
//   rdata_o    read data shifted down to bit 0, upper bits zero
module mem_lane_align
    import lsu_mem_ctrl_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        unique case (addr_lo_i)
            2'd0:    rd_byte = rdata_i[7:0];
            2'd1:    rd_byte = rdata_i[15:8];
            2'd2:    rd_byte = rdata_i[23:16];
            default: rd_byte = rdata_i[31:24];
        endcase
        rd_half = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    end

    always_comb begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rdata_i;
        case (size_i)
            SizeByte: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {24'b0, rd_byte};
            end
            SizeHalf: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {16'b0, rd_half};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                rdata_o = rdata_i;
            end
        endcase
    end

endmodule

// File: rtl/lsu_mem_ctrl.sv
// Data-memory controller between the LSU and a single-beat req/ack data bus.
// Accepts one operation in IDLE, runs one bus transaction (or flags it as
// misaligned without touching the bus), then pulses done for one cycle.
// Ports:
//   clock_in, reset_in        clock and synchronous active-high reset
//   mem_valid_in/op/addr/data  request from the LSU (op: store, unsigned, size)
//   mem_busy_out               high whenever not idle (combinational)
//   mem_done_out + data/flags  one-cycle completion with right-aligned load data
//   bus_req/we/be/addr/wdata   registered bus request, held until ack/timeout
//   bus_ack_in, bus_rdata_in   bus acknowledge and read word
module lsu_mem_ctrl
    import lsu_mem_ctrl_pkg::*;
#(
    parameter int unsigned XLEN           = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic            clock_in,
    input  logic            reset_in,
    input  logic            mem_valid_in,
    input  logic [3:0]      mem_op_in,
    input  logic [XLEN-1:0] mem_addr_in,
    input  logic [XLEN-1:0] mem_data_in,
    output logic            mem_busy_out,
    output logic            mem_done_out,
    output logic [XLEN-1:0] mem_data_out,
    output logic            mem_misaligned_out,
    output logic            mem_timeout_out,
    output logic            bus_req_out,
    output logic            bus_we_out,
    output logic [3:0]      bus_be_out,
    output logic [XLEN-1:0] bus_addr_out,
    output logic [XLEN-1:0] bus_wdata_out,
    input  logic            bus_ack_in,
    input  logic [XLEN-1:0] bus_rdata_in
);

    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYCLES - 1);

    mem_state_e state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      size_q, size_d;
    logic            store_q, store_d;
    logic [1:0]      addr_lo_q, addr_lo_d;

    logic            done_q, done_d;
    logic [XLEN-1:0] data_q, data_d;
    logic            mis_q, mis_d;
    logic            to_q, to_d;
    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] baddr_q, baddr_d;
    logic [XLEN-1:0] bwdata_q, bwdata_d;

    logic [1:0]      in_size;
    logic            in_store;
    logic [1:0]      lane_size;
    logic [1:0]      lane_addr_lo;
    logic [3:0]      lane_be;
    logic [XLEN-1:0] lane_wdata;
    logic [XLEN-1:0] lane_rdata;

    // Signedness is resolved in the LSU; the controller never looks at it.
    logic unused_op_unsigned;
    assign unused_op_unsigned = mem_op_in[OpUnsignedBit];

    assign in_size  = mem_op_in[OpSizeLsb +: 2];
    assign in_store = mem_op_in[OpStoreBit];

    // One aligner serves both directions: in IDLE it steers the incoming store
    // and enables; in BUS it uses the captured size/offset to align read data.
    assign lane_size    = (state_q == StIdle) ? in_size : size_q;
    assign lane_addr_lo = (state_q == StIdle) ? mem_addr_in[1:0] : addr_lo_q;

    mem_lane_align u_lane_align (
        .size_i    (lane_size),
        .addr_lo_i (lane_addr_lo),
        .wdata_i   (mem_data_in),
        .rdata_i   (bus_rdata_in),
        .be_o      (lane_be),
        .wdata_o   (lane_wdata),
        .rdata_o   (lane_rdata)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        size_d    = size_q;
        store_d   = store_q;
        addr_lo_d = addr_lo_q;
        done_d    = 1'b0;
        data_d    = '0;
        mis_d     = 1'b0;
        to_d      = 1'b0;
        req_d     = 1'b0;
        we_d      = 1'b0;
        be_d      = '0;
        baddr_d   = '0;
        bwdata_d  = '0;

        unique case (state_q)
            StIdle: begin
                if (mem_valid_in) begin
                    size_d    = in_size;
                    store_d   = in_store;
                    addr_lo_d = mem_addr_in[1:0];
                    cnt_d     = '0;
                    if (is_misaligned(in_size, mem_addr_in[1:0])) begin
                        state_d = StDone;
                        done_d  = 1'b1;
                        mis_d   = 1'b1;
                    end else begin
                        state_d  = StBus;
                        req_d    = 1'b1;
                        we_d     = in_store;
                        be_d     = lane_be;
                        baddr_d  = {mem_addr_in[XLEN-1:2], 2'b00};
                        bwdata_d = lane_wdata;
                    end
                end
            end
            StBus: begin
                // Ack is checked first so an ack on the final wait cycle wins.
                if (bus_ack_in) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    data_d  = store_q ? '0 : lane_rdata;
                end else if (cnt_q == CntLast) begin
                    state_d = StDone;
                    done_d  = 1'b1;
                    to_d    = 1'b1;
                end else begin
                    cnt_d    = cnt_q + CntW'(1);
                    req_d    = 1'b1;
                    we_d     = we_q;
                    be_d     = be_q;
                    baddr_d  = baddr_q;
                    bwdata_d = bwdata_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clock_in) begin
        if (reset_in) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            size_q    <= '0;
            store_q   <= 1'b0;
            addr_lo_q <= '0;
            done_q    <= 1'b0;
            data_q    <= '0;
            mis_q     <= 1'b0;
            to_q      <= 1'b0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= '0;
            baddr_q   <= '0;
            bwdata_q  <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            size_q    <= size_d;
            store_q   <= store_d;
            addr_lo_q <= addr_lo_d;
            done_q    <= done_d;
            data_q    <= data_d;
            mis_q     <= mis_d;
            to_q      <= to_d;
            req_q     <= req_d;
            we_q      <= we_d;
            be_q      <= be_d;
            baddr_q   <= baddr_d;
            bwdata_q  <= bwdata_d;
        end
    end

    assign mem_busy_out       = (state_q != StIdle);
    assign mem_done_out       = done_q;
    assign mem_data_out       = data_q;
    assign mem_misaligned_out = mis_q;
    assign mem_timeout_out    = to_q;
    assign bus_req_out        = req_q;
    assign bus_we_out         = we_q;
    assign bus_be_out         = be_q;
    assign bus_addr_out       = baddr_q;
    assign bus_wdata_out      = bwdata_q;

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Self-checking bench for lsu_mem_ctrl with a behavioural reference model.
module tb_lsu_mem_ctrl;

    localparam int T = 4;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid;
    logic [3:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata_out;
    logic        mis;
    logic        tmo;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic        ack;
    logic [31:0] brdata;

    int errors = 0;
    int checks = 0;

    typedef struct {
        int          done_cyc;
        int          req_cnt;
        int          busy_cnt;
        int          stable;
        logic [3:0]  be;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        mis;
        logic        tmo;
        logic        done_after;
        logic        busy_after;
    } obs_t;

    typedef struct {
        logic [3:0]  op;
        logic [31:0] addr;
    } req_t;

    always #5 clk = ~clk;

    lsu_mem_ctrl #(
        .XLEN           (32),
        .TIMEOUT_CYCLES (T)
    ) dut (
        .clock_in           (clk),
        .reset_in           (rst),
        .mem_valid_in       (valid),
        .mem_op_in          (op),
        .mem_addr_in        (addr),
        .mem_data_in        (wdata),
        .mem_busy_out       (busy),
        .mem_done_out       (done),
        .mem_data_out       (rdata_out),
        .mem_misaligned_out (mis),
        .mem_timeout_out    (tmo),
        .bus_req_out        (req),
        .bus_we_out         (we),
        .bus_be_out         (be),
        .bus_addr_out       (baddr),
        .bus_wdata_out      (bwdata),
        .bus_ack_in         (ack),
        .bus_rdata_in       (brdata)
    );

    // ---------------- reference model ----------------
    function automatic int m_size(logic [3:0] o);
        int s;
        s = int'(o) % 4;
        if (s == 0) s = 3;
        return s;  // 1 byte, 2 half, 3 word
    endfunction

    function automatic bit m_mis(logic [3:0] o, logic [31:0] a);
        if (m_size(o) == 1) return 0;
        if (m_size(o) == 2) return (a % 2) != 0;
        return (a % 4) != 0;
    endfunction

    function automatic logic [3:0] m_be(logic [3:0] o, logic [31:0] a);
        if (m_size(o) == 1) return 4'(1 << (a % 4));
        if (m_size(o) == 2) return ((a % 4) >= 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] m_wdata(logic [3:0] o, logic [31:0] d);
        if (m_size(o) == 1) return (d % 256) * 32'h0101_0101;
        if (m_size(o) == 2) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] m_rdata(logic [3:0] o, logic [31:0] a, logic [31:0] rd);
        if (o >= 8) return 0;
        if (m_size(o) == 1) return (rd >> (8 * (a % 4))) % 256;
        if (m_size(o) == 2) return (rd >> (16 * ((a / 2) % 2))) % 65536;
        return rd;
    endfunction

    // ---------------- driver (no checking) ----------------
    task automatic do_txn(input logic [3:0] o, input logic [31:0] a, input logic [31:0] d,
                          input int ack_wait, input logic [31:0] rd, output obs_t r);
        int cyc;
        int nreq;
        r = '{default: 0};
        r.done_cyc = -1;
        r.stable = 1;
        @(negedge clk);
        valid = 1'b1; op = o; addr = a; wdata = d;
        cyc = 0; nreq = 0;
        while (cyc < 40) begin
            @(negedge clk);
            cyc++;
            valid = 1'b0; op = 4'($urandom); addr = $urandom; wdata = $urandom;
            if (busy) r.busy_cnt++;
            if (req) begin
                if (nreq == 0) begin
                    r.be = be; r.we = we; r.addr = baddr; r.wdata = bwdata;
                end else if (be !== r.be || we !== r.we || baddr !== r.addr ||
                             bwdata !== r.wdata) begin
                    r.stable = 0;
                end
                ack = (nreq == ack_wait);
                brdata = ack ? rd : $urandom;
                nreq++;
            end else begin
                ack = 1'b0;
                brdata = $urandom;
            end
            if (done) begin
                r.done_cyc = cyc; r.data = rdata_out; r.mis = mis; r.tmo = tmo;
                break;
            end
        end
        r.req_cnt = nreq;
        @(negedge clk);
        ack = 1'b0;
        r.done_after = done;
        r.busy_after = busy;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; valid = 1'b0; op = 4'hF; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF;
        ack = 1'b1; brdata = 32'hFFFF_FFFF;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy, done, mis, tmo, req, we} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000", {busy, done, mis, tmo, req, we});
        end
        checks++;
        if ({rdata_out, baddr, bwdata, be} !== 100'b0) begin
            errors++;
            $display("FAIL reset_data: got %h/%h/%h/%h expected all zero",
                     rdata_out, baddr, bwdata, be);
        end
        rst = 1'b0; ack = 1'b0;
        @(negedge clk);
        checks++;
        if ({busy, req, done} !== 3'b0) begin
            errors++;
            $display("FAIL idle_ack_ignored: got %b expected 000", {busy, req, done});
        end
    endtask

    task automatic test_load_word();
        obs_t r;
        do_txn(4'b0011, 32'h100, 32'h0, 0, 32'hDEAD_BEEF, r);
        checks++;
        if (r.done_cyc !== 2) begin
            errors++; $display("FAIL lw_latency: got %0d expected 2", r.done_cyc);
        end
        checks++;
        if ({r.be, r.we, r.addr} !== {4'hF, 1'b0, 32'h100}) begin
            errors++;
            $display("FAIL lw_bus: got be=%h we=%b addr=%h expected be=f we=0 addr=100",
                     r.be, r.we, r.addr);
        end
        checks++;
        if (r.data !== 32'hDEAD_BEEF) begin
            errors++; $display("FAIL lw_data: got %h expected deadbeef", r.data);
        end
        checks++;
        if (r.done_after !== 1'b0 || r.busy_after !== 1'b0) begin
            errors++;
            $display("FAIL lw_single_pulse: got done=%b busy=%b expected 0 0",
                     r.done_after, r.busy_after);
        end
    endtask

    task automatic test_store_byte();
        obs_t r;
        do_txn(4'b1001, 32'h203, 32'h1234_56A5, 3, 32'h5555_5555, r);
        checks++;
        if ({r.be, r.we, r.addr, r.wdata} !== {4'h8, 1'b1, 32'h200, 32'hA5A5_A5A5}) begin
            errors++;
            $display("FAIL sb_bus: got be=%h we=%b addr=%h wdata=%h expected 8 1 200 a5a5a5a5",
                     r.be, r.we, r.addr, r.wdata);
        end
        checks++;
        if (r.done_cyc !== 5 || r.busy_cnt !== 5) begin
            errors++;
            $display("FAIL sb_timing: got done=%0d busy=%0d expected 5 5", r.done_cyc, r.busy_cnt);
        end
        checks++;
        if (r.data !== 32'h0 || r.stable !== 1) begin
            errors++;
            $display("FAIL sb_data_stable: got data=%h stable=%0d expected 0 1", r.data, r.stable);
        end
    endtask

    task automatic test_load_half();
        obs_t r;
        do_txn(4'b0010, 32'h102, 32'h0, 0, 32'h8001_7FFE, r);
        checks++;
        if (r.be !== 4'hC || r.data !== 32'h0000_8001) begin
            errors++;
            $display("FAIL lh_data: got be=%h data=%h expected c 00008001", r.be, r.data);
        end
        do_txn(4'b0010, 32'h101, 32'h0, 0, 32'h8001_7FFE, r);
        checks++;
        if (r.done_cyc !== 1 || r.mis !== 1'b1 || r.req_cnt !== 0) begin
            errors++;
            $display("FAIL lh_misaligned: got done=%0d mis=%b req=%0d expected 1 1 0",
                     r.done_cyc, r.mis, r.req_cnt);
        end
    endtask

    task automatic test_timeout();
        obs_t r;
        do_txn(4'b0011, 32'h40, 32'h0, NEVER, 32'h0, r);
        checks++;
        if (r.req_cnt !== T || r.done_cyc !== T + 1) begin
            errors++;
            $display("FAIL to_timing: got req=%0d done=%0d expected %0d %0d",
                     r.req_cnt, r.done_cyc, T, T + 1);
        end
        checks++;
        if (r.tmo !== 1'b1 || r.data !== 32'h0) begin
            errors++;
            $display("FAIL to_flag: got tmo=%b data=%h expected 1 0", r.tmo, r.data);
        end
        do_txn(4'b0011, 32'h40, 32'h0, T - 1, 32'h1357_9BDF, r);
        checks++;
        if (r.tmo !== 1'b0 || r.data !== 32'h1357_9BDF || r.done_cyc !== T + 1) begin
            errors++;
            $display("FAIL ack_at_threshold: got tmo=%b data=%h done=%0d expected 0 13579bdf %0d",
                     r.tmo, r.data, r.done_cyc, T + 1);
        end
    endtask

    task automatic test_reset_mid_bus();
        obs_t r;
        @(negedge clk);
        valid = 1'b1; op = 4'b0011; addr = 32'h300;
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (req !== 1'b1) begin
            errors++; $display("FAIL rst_mid_enter_bus: got req=%b expected 1", req);
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({req, busy, done} !== 3'b0) begin
            errors++; $display("FAIL rst_mid_drop: got %b expected 000", {req, busy, done});
        end
        ack = 1'b1; brdata = 32'hCAFE_F00D;
        @(negedge clk);
        ack = 1'b0;
        checks++;
        if ({req, busy, done, mis, tmo} !== 5'b0 || rdata_out !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_late_ack: got %b data=%h expected 00000 0",
                     {req, busy, done, mis, tmo}, rdata_out);
        end
        do_txn(4'b0000, 32'h304, 32'h0, 1, 32'h0BAD_CAFE, r);
        checks++;
        if (r.done_cyc !== 3 || r.data !== 32'h0BAD_CAFE) begin
            errors++;
            $display("FAIL rst_mid_recover: got done=%0d data=%h expected 3 0badcafe",
                     r.done_cyc, r.data);
        end
    endtask

    task automatic test_random();
        obs_t r;
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  o;
            logic [31:0] a, d, rd;
            int          w, exp_done, exp_req;
            bit          em, et;
            o = 4'($urandom); a = $urandom; d = $urandom; rd = $urandom;
            w = $urandom_range(0, T + 1);
            em = m_mis(o, a);
            et = !em && (w >= T);
            exp_done = em ? 1 : (et ? T + 1 : w + 2);
            exp_req  = em ? 0 : (et ? T : w + 1);
            do_txn(o, a, d, w, rd, r);
            checks++;
            if (r.done_cyc !== exp_done || r.req_cnt !== exp_req || r.busy_cnt !== exp_done) begin
                errors++;
                $display("FAIL rnd_timing[%0d]: got done=%0d req=%0d busy=%0d expected %0d %0d %0d",
                         i, r.done_cyc, r.req_cnt, r.busy_cnt, exp_done, exp_req, exp_done);
            end
            checks++;
            if (r.mis !== em || r.tmo !== et) begin
                errors++;
                $display("FAIL rnd_flags[%0d]: got mis=%b tmo=%b expected %b %b",
                         i, r.mis, r.tmo, em, et);
            end
            checks++;
            if (r.data !== ((em || et) ? 32'h0 : m_rdata(o, a, rd))) begin
                errors++;
                $display("FAIL rnd_data[%0d]: got %h expected %h", i, r.data,
                         (em || et) ? 32'h0 : m_rdata(o, a, rd));
            end
            if (!em) begin
                checks++;
                if (r.be !== m_be(o, a) || r.we !== o[3] || r.addr !== (a & ~32'h3)) begin
                    errors++;
                    $display("FAIL rnd_bus[%0d]: got be=%h we=%b addr=%h expected %h %b %h",
                             i, r.be, r.we, r.addr, m_be(o, a), o[3], a & ~32'h3);
                end
                checks++;
                if (r.wdata !== m_wdata(o, d) || r.stable !== 1) begin
                    errors++;
                    $display("FAIL rnd_wdata[%0d]: got %h stable=%0d expected %h 1",
                             i, r.wdata, r.stable, m_wdata(o, d));
                end
            end
            checks++;
            if (r.done_after !== 1'b0 || r.busy_after !== 1'b0) begin
                errors++;
                $display("FAIL rnd_return_idle[%0d]: got done=%b busy=%b expected 0 0",
                         i, r.done_after, r.busy_after);
            end
        end
    endtask

    task automatic test_back_to_back();
        req_t        q[$];
        req_t        e;
        logic [31:0] last_rd = '0;
        int          accepted = 0;
        int          completed = 0;
        for (int cyc = 0; cyc < 48; cyc++) begin
            @(negedge clk);
            if (done) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra_done: got done expected none");
                end else begin
                    e = q.pop_front();
                    if (rdata_out !== (m_mis(e.op, e.addr) ? 32'h0 : m_rdata(e.op, e.addr, last_rd))
                        || mis !== m_mis(e.op, e.addr) || tmo !== 1'b0) begin
                        errors++;
                        $display("FAIL b2b_done: got data=%h mis=%b tmo=%b for op=%h addr=%h",
                                 rdata_out, mis, tmo, e.op, e.addr);
                    end
                end
                completed++;
            end
            if (req) begin
                checks++;
                if (q.size() == 0 || be !== m_be(q[0].op, q[0].addr) || we !== q[0].op[3]) begin
                    errors++;
                    $display("FAIL b2b_bus: got be=%h we=%b queued=%0d", be, we, q.size());
                end
                ack = 1'b1;
                last_rd = $urandom;
                brdata = last_rd;
            end else begin
                ack = 1'b0;
            end
            if (cyc < 36) begin
                valid = 1'b1;
                op = 4'($urandom);
                addr = $urandom;
                wdata = $urandom;
                if (!busy) begin
                    e.op = op; e.addr = addr;
                    q.push_back(e);
                    accepted++;
                end
            end else begin
                valid = 1'b0;
            end
        end
        ack = 1'b0;
        checks++;
        if (completed !== accepted || q.size() !== 0 || accepted < 12) begin
            errors++;
            $display("FAIL b2b_count: got completed=%0d accepted=%0d left=%0d expected equal, >=12",
                     completed, accepted, q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_load_word();
        test_store_byte();
        test_load_half();
        test_timeout();
        test_reset_mid_bus();
        test_random();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
